// File: rtl/fetch_unit_if.sv
// Signal bundle between fetch_unit and its environment: control, redirect,
// instruction-memory handshake and fetched-instruction outputs.
interface fetch_unit_if;
  logic        fetch_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_ack;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic        fetch_fault;

  modport master (
    input  fetch_en, redirect_valid, redirect_pc, instr_ack,
           imem_gnt, imem_rvalid, imem_rdata,
    output imem_req, imem_addr, instr, instr_valid, pc, fetch_fault
  );

  modport slave (
    output fetch_en, redirect_valid, redirect_pc, instr_ack,
           imem_gnt, imem_rvalid, imem_rdata,
    input  imem_req, imem_addr, instr, instr_valid, pc, fetch_fault
  );
endinterface

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch unit: issues word reads at pc, holds the
// returned instruction until acknowledged, and handles redirects and faults.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic         clk,
  input logic         reset,
  fetch_unit_if.master bus
);

  typedef enum logic [3:0] {
    IDLE = 4'b0001,
    REQ  = 4'b0010,
    WAIT = 4'b0100,
    HOLD = 4'b1000
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic        fault_q, fault_d;
  logic        squash_q, squash_d;

  logic        misaligned;
  logic        start;

  assign misaligned = bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);
  assign start      = bus.fetch_en && !fault_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      instr_q  <= '0;
      valid_q  <= 1'b0;
      fault_q  <= 1'b0;
      squash_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      valid_q  <= valid_d;
      fault_q  <= fault_d;
      squash_q <= squash_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    valid_d  = valid_q;
    fault_d  = fault_q;
    squash_d = squash_q;
    case (state_q)
      IDLE: begin
        if (bus.redirect_valid) begin
          valid_d = 1'b0;
          if (misaligned) begin
            fault_d = 1'b1;
          end else begin
            pc_d = bus.redirect_pc;
            if (start) state_d = REQ;
          end
        end else if (start) begin
          state_d = REQ;
        end
      end
      REQ: begin
        if (bus.redirect_valid) begin
          if (misaligned) begin
            fault_d = 1'b1;
            // A granted request still owes a response; drain it before idling.
            if (bus.imem_gnt) begin
              state_d  = WAIT;
              squash_d = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else begin
            pc_d = bus.redirect_pc;
            if (bus.imem_gnt) begin
              state_d  = WAIT;
              squash_d = 1'b1;
            end
          end
        end else if (bus.imem_gnt) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (bus.redirect_valid) begin
          if (misaligned) fault_d = 1'b1;
          else            pc_d    = bus.redirect_pc;
          if (bus.imem_rvalid) begin
            squash_d = 1'b0;
            state_d  = (misaligned || fault_q) ? IDLE : REQ;
          end else begin
            squash_d = 1'b1;
          end
        end else if (bus.imem_rvalid) begin
          if (squash_q) begin
            squash_d = 1'b0;
            state_d  = fault_q ? IDLE : REQ;
          end else begin
            instr_d = bus.imem_rdata;
            valid_d = 1'b1;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (bus.redirect_valid) begin
          valid_d = 1'b0;
          if (misaligned) begin
            fault_d = 1'b1;
            state_d = IDLE;
          end else begin
            pc_d    = bus.redirect_pc;
            state_d = start ? REQ : IDLE;
          end
        end else if (bus.instr_ack) begin
          pc_d    = pc_q + 32'd4;
          valid_d = 1'b0;
          state_d = bus.fetch_en ? REQ : IDLE;
        end
      end
      default: begin
        state_d  = IDLE;
        valid_d  = 1'b0;
        squash_d = 1'b0;
      end
    endcase
  end

  assign bus.imem_req    = (state_q == REQ);
  assign bus.imem_addr   = pc_q;
  assign bus.instr       = instr_q;
  assign bus.instr_valid = valid_q;
  assign bus.pc          = pc_q;
  assign bus.fetch_fault = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: stimulus pushes expected grants and fetched
// instructions into queues; a negedge monitor pops and compares them.
module tb_fetch_unit;

  localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;

  logic clk;
  logic reset;
  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(TB_RESET_PC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;
  int n_grants = 0;
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_instr_q[$];
  logic [31:0] exp_pc_q[$];
  logic prev_iv = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    logic [31:0] e;
    if (!reset) begin
      if (bus.imem_req && bus.imem_gnt) begin
        n_grants++;
        if (exp_addr_q.size() == 0) begin
          vectors++;
          errors++;
          $display("FAIL unexpected_grant: got addr %h expected no request", bus.imem_addr);
        end else begin
          e = exp_addr_q.pop_front();
          chk("req_addr", bus.imem_addr, e);
        end
      end
      if (bus.instr_valid && !prev_iv) begin
        if (exp_instr_q.size() == 0) begin
          vectors++;
          errors++;
          $display("FAIL unexpected_instr: got instr %h expected none", bus.instr);
        end else begin
          e = exp_instr_q.pop_front();
          chk("instr", bus.instr, e);
          e = exp_pc_q.pop_front();
          chk("instr_pc", bus.pc, e);
        end
      end
    end
    prev_iv = bus.instr_valid;
  end

  task automatic wait_req();
    int n = 0;
    while (bus.imem_req !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    if (bus.imem_req !== 1'b1) chk("wait_req_timeout", {31'b0, bus.imem_req}, 32'd1);
  endtask

  task automatic grant(input int delay, input logic [31:0] addr);
    wait_req();
    for (int i = 0; i < delay; i++) begin
      chk("req_stable", {31'b0, bus.imem_req}, 32'd1);
      chk("addr_stable", bus.imem_addr, addr);
      step();
    end
    chk("req_stable", {31'b0, bus.imem_req}, 32'd1);
    chk("addr_stable", bus.imem_addr, addr);
    bus.imem_gnt = 1'b1;
    step();
    bus.imem_gnt = 1'b0;
  endtask

  task automatic respond(input logic [31:0] data);
    chk("wait_no_req", {31'b0, bus.imem_req}, 32'd0);
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = data;
    step();
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
  endtask

  task automatic expect_fetch(input logic [31:0] addr, input logic [31:0] data);
    exp_addr_q.push_back(addr);
    exp_instr_q.push_back(data);
    exp_pc_q.push_back(addr);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    bus.fetch_en = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    bus.instr_ack = 1'b0;
    bus.imem_gnt = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata = '0;
    repeat (3) step();
    chk("rst_pc", bus.pc, TB_RESET_PC);
    chk("rst_valid", {31'b0, bus.instr_valid}, 32'd0);
    chk("rst_instr", bus.instr, 32'd0);
    chk("rst_req", {31'b0, bus.imem_req}, 32'd0);
    chk("rst_fault", {31'b0, bus.fetch_fault}, 32'd0);
    reset = 1'b0;

    // Scenario 1: minimum latency fetch then ack
    expect_fetch(32'h0, 32'h0000_0013);
    bus.fetch_en = 1'b1;
    step();
    chk("s1_req", {31'b0, bus.imem_req}, 32'd1);
    chk("s1_addr", bus.imem_addr, 32'h0);
    bus.imem_gnt = 1'b1;
    step();
    bus.imem_gnt = 1'b0;
    chk("s1_valid_early", {31'b0, bus.instr_valid}, 32'd0);
    respond(32'h0000_0013);
    chk("s1_valid", {31'b0, bus.instr_valid}, 32'd1);
    chk("s1_instr", bus.instr, 32'h13);
    chk("s1_pc", bus.pc, 32'h0);
    step();
    chk("s1_hold", bus.instr, 32'h13);
    bus.instr_ack = 1'b1;
    step();
    bus.instr_ack = 1'b0;
    chk("s1_pc_ack", bus.pc, 32'h4);
    chk("s1_valid_ack", {31'b0, bus.instr_valid}, 32'd0);
    chk("s1_req_next", {31'b0, bus.imem_req}, 32'd1);
    chk("s1_addr_next", bus.imem_addr, 32'h4);

    // Scenario 2: grant withheld 3 cycles
    expect_fetch(32'h4, 32'h00A0_0093);
    grant(3, 32'h4);
    respond(32'h00A0_0093);
    chk("s2_valid", {31'b0, bus.instr_valid}, 32'd1);
    bus.fetch_en = 1'b0;
    bus.instr_ack = 1'b1;
    step();
    bus.instr_ack = 1'b0;
    chk("s2_pc", bus.pc, 32'h8);
    chk("s2_idle_req", {31'b0, bus.imem_req}, 32'd0);
    chk("s2_grants", n_grants, 32'd2);

    // Scenario 3: redirect during WAIT squashes the response
    bus.fetch_en = 1'b1;
    step();
    exp_addr_q.push_back(32'h8);
    grant(0, 32'h8);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h100;
    step();
    bus.redirect_valid = 1'b0;
    chk("s3_wait_req", {31'b0, bus.imem_req}, 32'd0);
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata = 32'hDEAD_BEEF;
    step();
    bus.imem_rvalid = 1'b0;
    chk("s3_valid", {31'b0, bus.instr_valid}, 32'd0);
    chk("s3_instr_kept", bus.instr, 32'h00A0_0093);
    chk("s3_req", {31'b0, bus.imem_req}, 32'd1);
    chk("s3_addr", bus.imem_addr, 32'h100);
    expect_fetch(32'h100, 32'h1357_9BDF);
    grant(0, 32'h100);
    respond(32'h1357_9BDF);

    // Scenario 4: misaligned redirect in HOLD faults
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h102;
    step();
    bus.redirect_valid = 1'b0;
    chk("s4_fault", {31'b0, bus.fetch_fault}, 32'd1);
    chk("s4_valid", {31'b0, bus.instr_valid}, 32'd0);
    chk("s4_pc", bus.pc, 32'h100);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("s4_no_req", {31'b0, bus.imem_req}, 32'd0);
    end
    chk("s4_fault_sticky", {31'b0, bus.fetch_fault}, 32'd1);
    reset = 1'b1;
    bus.fetch_en = 1'b0;
    step();
    reset = 1'b0;
    chk("s4_fault_clr", {31'b0, bus.fetch_fault}, 32'd0);

    // Scenario 5: PC wrap
    bus.fetch_en = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFFC;
    step();
    bus.redirect_valid = 1'b0;
    expect_fetch(32'hFFFF_FFFC, 32'h0000_0073);
    grant(0, 32'hFFFF_FFFC);
    respond(32'h0000_0073);
    bus.fetch_en = 1'b0;
    bus.instr_ack = 1'b1;
    step();
    bus.instr_ack = 1'b0;
    chk("s5_pc_wrap", bus.pc, 32'h0);
    chk("s5_fault", {31'b0, bus.fetch_fault}, 32'd0);

    // Scenario 7: redirects in REQ, ack ignored outside HOLD, redirect+rvalid
    bus.fetch_en = 1'b1;
    step();
    bus.instr_ack = 1'b1;
    step();
    bus.instr_ack = 1'b0;
    chk("s7_ack_ignored", bus.pc, 32'h0);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h40;
    step();
    bus.redirect_valid = 1'b0;
    chk("s7_req", {31'b0, bus.imem_req}, 32'd1);
    chk("s7_addr", bus.imem_addr, 32'h40);
    exp_addr_q.push_back(32'h40);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h200;
    bus.imem_gnt = 1'b1;
    step();
    bus.imem_gnt = 1'b0;
    bus.redirect_valid = 1'b0;
    chk("s7_wait_req", {31'b0, bus.imem_req}, 32'd0);
    chk("s7_pc200", bus.pc, 32'h200);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h300;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata = 32'hCAFE_F00D;
    step();
    bus.redirect_valid = 1'b0;
    bus.imem_rvalid = 1'b0;
    chk("s7_valid", {31'b0, bus.instr_valid}, 32'd0);
    chk("s7_req300", {31'b0, bus.imem_req}, 32'd1);
    chk("s7_addr300", bus.imem_addr, 32'h300);
    expect_fetch(32'h300, 32'h0BAD_C0DE);
    grant(0, 32'h300);
    respond(32'h0BAD_C0DE);
    chk("s7_valid_final", {31'b0, bus.instr_valid}, 32'd1);

    // Scenario 6: reset while waiting, late response ignored
    bus.instr_ack = 1'b1;
    step();
    bus.instr_ack = 1'b0;
    exp_addr_q.push_back(32'h304);
    grant(0, 32'h304);
    reset = 1'b1;
    bus.fetch_en = 1'b0;
    step();
    reset = 1'b0;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata = 32'hFFFF_FFFF;
    step();
    bus.imem_rvalid = 1'b0;
    chk("s6_valid", {31'b0, bus.instr_valid}, 32'd0);
    chk("s6_pc", bus.pc, TB_RESET_PC);
    chk("s6_instr", bus.instr, 32'h0);
    chk("s6_req", {31'b0, bus.imem_req}, 32'd0);
    step();
    chk("s6_idle", {31'b0, bus.imem_req}, 32'd0);

    chk("left_addr", exp_addr_q.size(), 32'd0);
    chk("left_instr", exp_instr_q.size(), 32'd0);
    chk("total_grants", n_grants, 32'd8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
